// File: rtl/uart_tcm_boot_loader_if.sv
// AHB-Lite single-write bus between the boot loader (master) and the TCM (slave).
interface uart_tcm_boot_loader_if;
  logic [31:0] ahb_haddr_o;
  logic [1:0]  ahb_htrans_o;
  logic        ahb_hwrite_o;
  logic [2:0]  ahb_hsize_o;
  logic [2:0]  ahb_hburst_o;
  logic [3:0]  ahb_hprot_o;
  logic [31:0] ahb_hwdata_o;
  logic        ahb_hready_i;
  logic        ahb_hresp_i;

  modport master (
    output ahb_haddr_o, ahb_htrans_o, ahb_hwrite_o, ahb_hsize_o,
           ahb_hburst_o, ahb_hprot_o, ahb_hwdata_o,
    input  ahb_hready_i, ahb_hresp_i
  );

  modport slave (
    input  ahb_haddr_o, ahb_htrans_o, ahb_hwrite_o, ahb_hsize_o,
           ahb_hburst_o, ahb_hprot_o, ahb_hwdata_o,
    output ahb_hready_i, ahb_hresp_i
  );
endinterface

// File: rtl/uart_tcm_boot_loader.sv
// UART byte stream -> TCM boot loader: parses the image, writes words over
// AHB-Lite one at a time and releases the core once the checksum matches.
module uart_tcm_boot_loader #(
  parameter logic [31:0] TCM_BASE  = 32'hF000_0000,
  parameter int unsigned MAX_WORDS = 16384,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_valid_i,
  uart_tcm_boot_loader_if.master        ahb,
  output logic                          core_rst_o,
  output logic                          boot_done_o,
  output logic                          boot_err_o,
  output logic [2:0]                    err_code_o,
  output logic [15:0]                   words_written_o
);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] ERR_LEN       = 3'd1;
  localparam logic [2:0] ERR_CSUM      = 3'd2;
  localparam logic [2:0] ERR_BUS       = 3'd3;
  localparam logic [2:0] ERR_OVR       = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_FLUSH, S_DONE, S_ERROR
  } rx_state_t;

  typedef enum logic [1:0] {A_IDLE, A_ADDR, A_DATA} ahb_state_t;

  rx_state_t   r_state, w_state;
  ahb_state_t  r_astate, w_astate;
  logic [15:0] r_len, w_len;
  logic [7:0]  r_csum, w_csum;
  logic [1:0]  r_byte_idx, w_byte_idx;
  logic [23:0] r_word, w_word;
  logic [15:0] r_word_idx, w_word_idx;
  logic        r_hold_full, w_hold_full;
  logic [31:0] r_hold_data, w_hold_data;
  logic [31:0] r_hold_addr, w_hold_addr;
  logic [2:0]  r_err_code, w_err_code;
  logic [15:0] r_words_written, w_words_written;
  logic [31:0] r_haddr, r_hwdata;
  logic [1:0]  r_htrans;
  logic        r_hwrite, r_core_rst, r_boot_done, r_boot_err;
  logic [15:0] w_n;
  logic        w_xfer_end, w_xfer_ok, w_bus_err;

  // Next-state for the receive parser, the holding register and the AHB master
  always_comb begin
    w_state         = r_state;
    w_astate        = r_astate;
    w_len           = r_len;
    w_csum          = r_csum;
    w_byte_idx      = r_byte_idx;
    w_word          = r_word;
    w_word_idx      = r_word_idx;
    w_hold_full     = r_hold_full;
    w_hold_data     = r_hold_data;
    w_hold_addr     = r_hold_addr;
    w_err_code      = r_err_code;
    w_words_written = r_words_written;
    w_n             = {rx_data_i, r_len[7:0]};
    w_xfer_end      = (r_astate == A_DATA) && ahb.ahb_hready_i;
    w_xfer_ok       = w_xfer_end && !ahb.ahb_hresp_i;
    // a response arriving after ERROR is already latched is ignored
    w_bus_err       = w_xfer_end && ahb.ahb_hresp_i && (r_state != S_ERROR);

    unique case (r_astate)
      A_IDLE:  if (r_hold_full && (r_state != S_ERROR)) w_astate = A_ADDR;
      A_ADDR:  if (ahb.ahb_hready_i) w_astate = A_DATA;
      A_DATA:  if (ahb.ahb_hready_i) w_astate = A_IDLE;
      default: w_astate = A_IDLE;
    endcase

    if (w_xfer_end) w_hold_full = 1'b0;
    if (w_xfer_ok)  w_words_written = r_words_written + 16'd1;

    if (rx_valid_i) begin
      case (r_state)
        S_IDLE: if (rx_data_i == SYNC_BYTE) w_state = S_LEN0;
        S_LEN0: begin
          w_len      = {8'h00, rx_data_i};
          w_csum     = rx_data_i;
          w_byte_idx = 2'd0;
          w_word_idx = 16'd0;
          w_state    = S_LEN1;
        end
        S_LEN1: begin
          w_len  = w_n;
          w_csum = r_csum ^ rx_data_i;
          if (32'(w_n) > MAX_WORDS) begin
            w_state    = S_ERROR;
            w_err_code = ERR_LEN;
          end else if (w_n == 16'd0) begin
            w_state = S_CSUM;
          end else begin
            w_state = S_DATA;
          end
        end
        S_DATA: begin
          w_csum     = r_csum ^ rx_data_i;
          w_byte_idx = r_byte_idx + 2'd1;
          case (r_byte_idx)
            2'd0:    w_word[7:0]   = rx_data_i;
            2'd1:    w_word[15:8]  = rx_data_i;
            2'd2:    w_word[23:16] = rx_data_i;
            default: ;
          endcase
          if (r_byte_idx == 2'd3) begin
            // the holding slot frees up this cycle if the pending write completes
            if (r_hold_full && !w_xfer_end) begin
              w_state    = S_ERROR;
              w_err_code = ERR_OVR;
            end else begin
              w_hold_full = 1'b1;
              w_hold_data = {rx_data_i, r_word};
              w_hold_addr = TCM_BASE + 32'({r_word_idx, 2'b00});
              w_word_idx  = r_word_idx + 16'd1;
              if (r_word_idx == (r_len - 16'd1)) w_state = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (rx_data_i == r_csum) begin
            w_state = S_FLUSH;
          end else begin
            w_state    = S_ERROR;
            w_err_code = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end

    if ((r_state == S_FLUSH) && !r_hold_full && (r_astate == A_IDLE)) w_state = S_DONE;

    // bus error outranks every receive-side error raised in the same cycle
    if (w_bus_err) begin
      w_state    = S_ERROR;
      w_err_code = ERR_BUS;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= S_IDLE;
      r_astate        <= A_IDLE;
      r_len           <= '0;
      r_csum          <= '0;
      r_byte_idx      <= '0;
      r_word          <= '0;
      r_word_idx      <= '0;
      r_hold_full     <= 1'b0;
      r_hold_data     <= '0;
      r_hold_addr     <= '0;
      r_err_code      <= '0;
      r_words_written <= '0;
    end else begin
      r_state         <= w_state;
      r_astate        <= w_astate;
      r_len           <= w_len;
      r_csum          <= w_csum;
      r_byte_idx      <= w_byte_idx;
      r_word          <= w_word;
      r_word_idx      <= w_word_idx;
      r_hold_full     <= w_hold_full;
      r_hold_data     <= w_hold_data;
      r_hold_addr     <= w_hold_addr;
      r_err_code      <= w_err_code;
      r_words_written <= w_words_written;
    end
  end

  // Registered bus and status outputs, decoded from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_haddr     <= '0;
      r_hwdata    <= '0;
      r_htrans    <= HTRANS_IDLE;
      r_hwrite    <= 1'b0;
      r_core_rst  <= 1'b1;
      r_boot_done <= 1'b0;
      r_boot_err  <= 1'b0;
    end else begin
      r_htrans    <= (w_astate == A_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      r_hwrite    <= (w_astate == A_ADDR);
      if ((r_astate == A_IDLE) && (w_astate == A_ADDR)) r_haddr  <= r_hold_addr;
      if ((r_astate == A_ADDR) && (w_astate == A_DATA)) r_hwdata <= r_hold_data;
      r_core_rst  <= (w_state != S_DONE);
      r_boot_done <= (w_state == S_DONE);
      r_boot_err  <= (w_state == S_ERROR);
    end
  end

  assign ahb.ahb_haddr_o  = r_haddr;
  assign ahb.ahb_htrans_o = r_htrans;
  assign ahb.ahb_hwrite_o = r_hwrite;
  assign ahb.ahb_hsize_o  = 3'b010;
  assign ahb.ahb_hburst_o = 3'b000;
  assign ahb.ahb_hprot_o  = 4'b0011;
  assign ahb.ahb_hwdata_o = r_hwdata;
  assign core_rst_o       = r_core_rst;
  assign boot_done_o      = r_boot_done;
  assign boot_err_o       = r_boot_err;
  assign err_code_o       = r_err_code;
  assign words_written_o  = r_words_written;
endmodule

// File: tb/tb_uart_tcm_boot_loader.sv
// Bench for uart_tcm_boot_loader: directed image cases plus randomized images
// checked against an image-level reference model and an AHB slave monitor.
module tb_uart_tcm_boot_loader;
  localparam logic [31:0] TCM_BASE = 32'hF000_0000;

  logic        clk, rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        core_rst, boot_done, boot_err;
  logic [2:0]  err_code;
  logic [15:0] words_written;

  uart_tcm_boot_loader_if bus();

  uart_tcm_boot_loader #(
    .TCM_BASE(TCM_BASE), .MAX_WORDS(16384), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .ahb(bus), .core_rst_o(core_rst), .boot_done_o(boot_done),
    .boot_err_o(boot_err), .err_code_o(err_code), .words_written_o(words_written)
  );

  int n_total = 0, n_pass = 0, n_fail = 0;
  int ws = 0, err_idx = -1, nwrites = 0, nonseq_cnt = 0, stab_err = 0, cr_err = 0;
  bit stall = 0;
  logic [31:0] log_a[$], log_d[$];
  int          log_c[$];
  bit          dphase = 0, rst_edge;
  int          acnt = 0, dcnt = 0, acyc = 0;
  logic [31:0] asnap, dsnap;

  logic [7:0]  img[$];
  logic [31:0] m_words[$];
  bit          m_done;
  int          m_code;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // AHB slave: programmable wait states / error, logs writes, checks stability
  initial begin
    bus.ahb_hready_i = 1'b1;
    bus.ahb_hresp_i  = 1'b0;
    forever begin
      @(posedge clk);
      rst_edge = rst;
      #1;
      if (rst_edge) begin
        dphase = 0; acnt = 0; dcnt = 0;
      end
      bus.ahb_hresp_i = 1'b0;
      if (stall) begin
        bus.ahb_hready_i = 1'b0;
      end else if (dphase) begin
        if (bus.ahb_htrans_o !== 2'b00) stab_err++;
        if (dcnt == 0) dsnap = bus.ahb_hwdata_o;
        else if (bus.ahb_hwdata_o !== dsnap) stab_err++;
        if (dcnt >= ws) begin
          bus.ahb_hready_i = 1'b1;
          bus.ahb_hresp_i  = (nwrites == err_idx);
          log_a.push_back(asnap);
          log_d.push_back(bus.ahb_hwdata_o);
          log_c.push_back(acyc + dcnt + 1);
          nwrites++;
          dphase = 0;
        end else begin
          bus.ahb_hready_i = 1'b0;
        end
        dcnt++;
      end else if (bus.ahb_htrans_o === 2'b10) begin
        nonseq_cnt++;
        if (bus.ahb_hwrite_o !== 1'b1) stab_err++;
        if (acnt == 0) asnap = bus.ahb_haddr_o;
        else if (bus.ahb_haddr_o !== asnap) stab_err++;
        if (acnt >= ws) begin
          bus.ahb_hready_i = 1'b1;
          dphase = 1; dcnt = 0; acyc = acnt + 1; acnt = 0;
        end else begin
          bus.ahb_hready_i = 1'b0;
          acnt++;
        end
      end else begin
        bus.ahb_hready_i = 1'b1;
        acnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    if (core_rst !== !boot_done) cr_err++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic send_img(input int gap);
    foreach (img[i]) send_byte(img[i], gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    log_a.delete(); log_d.delete(); log_c.delete();
    nwrites = 0; nonseq_cnt = 0; stab_err = 0; cr_err = 0;
    cyc();
  endtask

  task automatic wait_end(input int max_cyc);
    int i = 0;
    while (!(boot_done || boot_err) && i < max_cyc) begin
      cyc();
      i++;
    end
    chk("end_reached", 32'(boot_done || boot_err), 32'd1);
    repeat (30) cyc();
  endtask

  // Reference model: decode the byte image into expected words and outcome
  task automatic model_img();
    int p = 0;
    int n;
    logic [7:0] x;
    m_words.delete();
    m_done = 0;
    m_code = 0;
    while (p < img.size() && img[p] != 8'hA5) p++;
    if (p + 2 >= img.size()) return;
    n = int'({img[p+2], img[p+1]});
    x = img[p+1] ^ img[p+2];
    if (n > 16384) begin
      m_code = 1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      logic [31:0] word = '0;
      for (int k = 0; k < 4; k++) begin
        word = word | (32'(img[p + 3 + 4*w + k]) << (8*k));
        x = x ^ img[p + 3 + 4*w + k];
      end
      m_words.push_back(word);
    end
    if (img[p + 3 + 4*n] == x) m_done = 1;
    else m_code = 2;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_done"},  32'(boot_done), 32'(m_done));
    chk({tag, "_err"},   32'(boot_err), 32'(m_code != 0));
    chk({tag, "_code"},  32'(err_code), 32'(m_code));
    chk({tag, "_crst"},  32'(core_rst), 32'(!m_done));
    chk({tag, "_ww"},    32'(words_written), 32'(m_words.size()));
    chk({tag, "_nlog"},  32'(log_a.size()), 32'(m_words.size()));
    for (int i = 0; i < m_words.size(); i++) begin
      chk({tag, "_addr"}, (i < log_a.size()) ? log_a[i] : 32'hxxxx_xxxx, TCM_BASE + 32'(4*i));
      chk({tag, "_data"}, (i < log_d.size()) ? log_d[i] : 32'hxxxx_xxxx, m_words[i]);
    end
    chk({tag, "_stable"}, 32'(stab_err), 32'd0);
    chk({tag, "_crst_inv"}, 32'(cr_err), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_htrans"}, 32'(bus.ahb_htrans_o), 32'd0);
    chk({tag, "_hwrite"}, 32'(bus.ahb_hwrite_o), 32'd0);
    chk({tag, "_haddr"},  bus.ahb_haddr_o, 32'd0);
    chk({tag, "_hwdata"}, bus.ahb_hwdata_o, 32'd0);
    chk({tag, "_hsize"},  32'(bus.ahb_hsize_o), 32'd2);
    chk({tag, "_hburst"}, 32'(bus.ahb_hburst_o), 32'd0);
    chk({tag, "_hprot"},  32'(bus.ahb_hprot_o), 32'd3);
    chk({tag, "_crst"},   32'(core_rst), 32'd1);
    chk({tag, "_done"},   32'(boot_done), 32'd0);
    chk({tag, "_err"},    32'(boot_err), 32'd0);
    chk({tag, "_code"},   32'(err_code), 32'd0);
    chk({tag, "_ww"},     32'(words_written), 32'd0);
  endtask

  task automatic load_good(input logic [7:0] csum);
    img = '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, csum};
  endtask

  initial begin
    bit found;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    cyc(); cyc();
    check_reset_vals("reset");
    rst = 1'b0;
    do_reset();

    // good image, zero wait states
    load_good(8'h64);
    model_img();
    send_img(0);
    wait_end(200);
    check_model("good");
    foreach (log_c[i]) chk("good_xfer_cycles", 32'(log_c[i]), 32'd2);

    // bad checksum, then a later image must be ignored
    do_reset();
    load_good(8'h65);
    model_img();
    send_img(0);
    wait_end(200);
    check_model("badcsum");
    img = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_img(0);
    repeat (20) cyc();
    chk("sticky_code", 32'(err_code), 32'd2);
    chk("sticky_ww", 32'(words_written), 32'd2);
    chk("sticky_nonseq", 32'(nonseq_cnt), 32'd2);

    // length too large: error right after LEN_HI, no bus activity
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h40, 0);
    chk("len_err_now", 32'(boot_err), 32'd1);
    chk("len_code_now", 32'(err_code), 32'd1);
    repeat (10) cyc();
    img = '{8'hA5, 8'h01, 8'h40};
    model_img();
    check_model("len");
    chk("len_nonseq", 32'(nonseq_cnt), 32'd0);

    // empty image
    do_reset();
    img = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_img();
    send_img(0);
    wait_end(50);
    check_model("empty");

    // three wait states in each phase
    do_reset();
    ws = 3;
    load_good(8'h64);
    model_img();
    send_img(3);
    wait_end(400);
    check_model("wait");
    foreach (log_c[i]) chk("wait_xfer_cycles", 32'(log_c[i]), 32'd8);
    ws = 0;

    // bus error on word 0
    do_reset();
    err_idx = 0;
    load_good(8'h64);
    send_img(0);
    wait_end(200);
    chk("buserr_err", 32'(boot_err), 32'd1);
    chk("buserr_code", 32'(err_code), 32'd3);
    chk("buserr_ww", 32'(words_written), 32'd0);
    chk("buserr_nonseq", 32'(nonseq_cnt), 32'd1);
    chk("buserr_crst", 32'(core_rst), 32'd1);
    err_idx = -1;

    // overrun with the bus stalled
    do_reset();
    stall = 1;
    load_good(8'h64);
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    chk("ovr_pre_err", 32'(boot_err), 32'd0);
    send_byte(img[10], 0);
    chk("ovr_err", 32'(boot_err), 32'd1);
    chk("ovr_code", 32'(err_code), 32'd4);
    chk("ovr_ww", 32'(words_written), 32'd0);
    do_reset();
    stall = 0;

    // reset during the address phase of word 1
    do_reset();
    load_good(8'h64);
    for (int i = 0; i < 11; i++) send_byte(img[i], 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.ahb_htrans_o === 2'b10 && bus.ahb_haddr_o === TCM_BASE + 32'd4) found = 1;
      else cyc();
    end
    chk("midrst_addr_seen", 32'(found), 32'd1);
    rst = 1'b1;
    cyc();
    check_reset_vals("midrst");
    rst = 1'b0;
    do_reset();
    model_img();
    send_img(0);
    wait_end(200);
    check_model("after_rst");

    // randomized images
    for (int t = 0; t < 10; t++) begin
      int n, mode, pre;
      logic [7:0] x, b;
      do_reset();
      ws   = $urandom_range(0, 2);
      mode = $urandom_range(0, 9);
      pre  = $urandom_range(0, 3);
      img.delete();
      for (int i = 0; i < pre; i++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        img.push_back(b);
      end
      n = (mode == 0) ? $urandom_range(16385, 65535) : $urandom_range(0, 5);
      img.push_back(8'hA5);
      img.push_back(8'(n));
      img.push_back(8'(n >> 8));
      x = 8'(n) ^ 8'(n >> 8);
      if (mode == 0) begin
        for (int i = 0; i < 3; i++) img.push_back(8'($urandom));
      end else begin
        for (int i = 0; i < 4*n; i++) begin
          b = 8'($urandom);
          x = x ^ b;
          img.push_back(b);
        end
        if (mode >= 6) x = x ^ 8'(1 << $urandom_range(0, 7));
        img.push_back(x);
      end
      model_img();
      send_img(3);
      wait_end(1000);
      check_model("rand");
    end
    ws = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tcm_boot_loader.md
Name: uart_tcm_boot_loader

Overview:
- Upstream feeder of the RISC-V core subsystem. Receives a firmware image as a byte stream from the UART receive path and writes it word by word into the core TCM.
- Writes go over an AHB-Lite master port (single NONSEQ word writes).
- Holds the core in reset until a complete image with a matching checksum has been written. This replaces file preloading of TCM with a real boot path.

Parameters:
- TCM_BASE, 32'hF000_0000, byte address of the first TCM word written.
- MAX_WORDS, 16384, largest accepted word count (64 KiB TCM).
- SYNC_BYTE, 8'hA5, image start marker.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- rx_data_i  in  8  received UART byte
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- ahb_haddr_o  out  32  AHB address
- ahb_htrans_o  out  2  AHB transfer type: IDLE=00, NONSEQ=10
- ahb_hwrite_o  out  1  write strobe, 1 during NONSEQ
- ahb_hsize_o  out  3  constant 3'b010 (word)
- ahb_hburst_o  out  3  constant 3'b000 (SINGLE)
- ahb_hprot_o  out  4  constant 4'b0011
- ahb_hwdata_o  out  32  write data
- ahb_hready_i  in  1  AHB ready
- ahb_hresp_i  in  1  AHB error response
- core_rst_o  out  1  active-high core reset request
- boot_done_o  out  1  image loaded and verified (sticky)
- boot_err_o  out  1  load failed (sticky)
- err_code_o  out  3  0 none, 1 length, 2 checksum, 3 bus error, 4 overrun
- words_written_o  out  16  count of completed AHB writes

Behaviour:
- Reset values: all outputs 0, except core_rst_o=1 and ahb_hsize_o/ahb_hburst_o/ahb_hprot_o at their constants. A reset mid-operation aborts everything; ahb_htrans_o is IDLE from the first edge with rst_i=1.
- Image format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), N×4 data bytes little-endian per word, then CSUM.
- CSUM is the XOR of LEN_LO, LEN_HI and all data bytes.
- Receive FSM states: IDLE, LEN0, LEN1, DATA, CSUM, FLUSH, DONE, ERROR.
- IDLE: bytes other than SYNC_BYTE are ignored; SYNC_BYTE moves to LEN0.
- LEN0 -> LEN1 on the next byte, which is stored as LEN_LO.
- LEN1 behaviour on the next byte (LEN_HI):
  - N > MAX_WORDS -> ERROR, code 1, no AHB activity.
  - N = 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: byte k of a word goes to bits [8k+7:8k]. On the 4th byte the assembled word moves to a one-entry holding register (hold_full=1) with address TCM_BASE + 4×index.
  - If hold_full is already 1 when the 4th byte arrives -> ERROR, code 4.
  - After word N-1 is assembled -> CSUM.
- CSUM: on the byte, compare with the running XOR.
  - Mismatch -> ERROR, code 2.
  - Match -> FLUSH.
- FLUSH: wait until hold_full=0 and no AHB transfer is outstanding, then DONE.
- DONE: boot_done_o=1 and core_rst_o=0 from the same cycle.
- ERROR: boot_err_o=1, core_rst_o stays 1, err_code_o is held.
- DONE and ERROR are sticky until rst_i. rx_valid_i is ignored in both.
- AHB sub-FSM states: A_IDLE, A_ADDR, A_DATA.
  - A_IDLE: when hold_full=1 and not in ERROR -> A_ADDR.
  - A_ADDR: drive htrans=NONSEQ, hwrite=1, haddr. Hold them until a cycle with hready_i=1, then -> A_DATA.
  - A_DATA: htrans=IDLE; drive hwdata, held stable until hready_i=1.
  - On hready_i=1 with hresp_i=0: clear hold_full, increment words_written_o, -> A_IDLE.
  - On hready_i=1 with hresp_i=1: ERROR, code 3.
- Minimum 2 cycles per write with zero wait states.
- A new address phase is never pipelined into a data phase (one outstanding write only).
- Once ERROR is entered, no new address phase starts. An in-flight data phase completes, but its response is ignored.
- Simultaneous events:
  - hold_full clearing and a 4th byte arriving in the same cycle: the new word is accepted, no overrun.
  - Multiple error conditions in one cycle: priority 3 > 4 > 2 > 1.
- address = TCM_BASE + {index,2'b00}, 32-bit wrap-around; no range check beyond MAX_WORDS.

Test Plan:
- Good image: A5 02 00 44 33 22 11 EF BE AD DE 64, hready_i=1 -> writes 0x11223344 @F000_0000 and 0xDEADBEEF @F000_0004, each a 2-cycle transfer. Then boot_done_o=1, core_rst_o=0, words_written_o=2.
- Same image with CSUM 65 -> both writes occur; boot_err_o=1, err_code_o=2, core_rst_o stays 1. Later bytes (e.g. a new A5 image) are ignored.
- Length check and empty image:
  - A5 01 40 (N=0x4001) -> ERROR code 1 right after LEN_HI, ahb_htrans_o never NONSEQ.
  - A5 00 00 00 -> DONE with zero writes.
- Wait states and bus error: hready_i low 3 cycles in each phase -> haddr and hwdata stable throughout; good image still completes. hresp_i=1 in the data phase of word 0 -> err_code_o=3, word 1 is never issued.
- Overrun: ahb_hready_i held 0, 8 data bytes back-to-back after the header -> ERROR code 4 on the 8th byte.
- Reset mid-transfer: rst_i pulsed during the A_ADDR of word 1 -> next cycle all outputs at reset values and htrans=IDLE. The full good image then loads correctly with words_written_o=2.
